// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one external up-counter between two one-shot
// interval-timer requesters; drives the counter's clear/enable, all outputs registered.
module counter_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] dur0,
  input  logic [WIDTH-1:0] dur1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_clr,
  output logic             cnt_en,
  input  logic [WIDTH-1:0] cnt_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_lsp;
  logic             w_lsp_nxt;
  logic [WIDTH-1:0] r_dur_q;
  logic [WIDTH-1:0] w_dur_nxt;
  logic [WIDTH-1:0] w_dur_last;

  logic             w_win;
  logic [WIDTH-1:0] w_win_dur;
  logic             w_own_req;

  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_cnt_clr;
  logic             r_cnt_en;

  logic [1:0]       w_owner_oh;
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       w_done_nxt;
  logic             w_busy_nxt;
  logic             w_cnt_clr_nxt;
  logic             w_cnt_en_nxt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_win      = (req == 2'b11) ? ~r_lsp : req[1];
    w_win_dur  = w_win ? dur1 : dur0;
    w_own_req  = req[r_owner];
    w_dur_last = r_dur_q - WIDTH'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lsp_nxt   = r_lsp;
    w_dur_nxt   = r_dur_q;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_owner_nxt = w_win;
          w_dur_nxt   = w_win_dur;
          w_state_nxt = (w_win_dur == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        if (!w_own_req) begin
          w_state_nxt = IDLE;
          w_lsp_nxt   = r_owner;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A dropped request aborts even on the final run cycle: no done pulse.
        if (!w_own_req) begin
          w_state_nxt = IDLE;
          w_lsp_nxt   = r_owner;
        end else if (cnt_value >= w_dur_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_lsp_nxt   = r_owner;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    w_owner_oh    = w_owner_nxt ? 2'b10 : 2'b01;
    w_gnt_nxt     = (w_state_nxt != IDLE) ? w_owner_oh : 2'b00;
    w_done_nxt    = (w_state_nxt == DONE) ? w_owner_oh : 2'b00;
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_cnt_clr_nxt = (w_state_nxt == CLEAR);
    w_cnt_en_nxt  = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_lsp     <= 1'b1;
      r_dur_q   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_cnt_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lsp     <= w_lsp_nxt;
      r_dur_q   <= w_dur_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign busy    = r_busy;
  assign cnt_clr = r_cnt_clr;
  assign cnt_en  = r_cnt_en;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: external counter model, table-driven single
// transactions, done-pulse scoreboard, and hand-built multi-cycle corner cases.
module tb_counter_sched;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] dur0;
  logic [W-1:0] dur1;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         busy;
  logic         cnt_clr;
  logic         cnt_en;
  logic [W-1:0] cnt_value;

  logic [W-1:0] r_cnt;
  logic         ovr_en;
  logic [W-1:0] ovr_val;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_since_clr = 0;

  typedef struct {
    logic [1:0] done;
    int         t0;
    int         lat;
    int         en;
  } sb_t;

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   gnt;
    int           lat;
    int           en;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vt[7];

  counter_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dur0      (dur0),
    .dur1      (dur1),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .cnt_value (cnt_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External counter the scheduler controls; ovr_en injects a corrupted value.
  always @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (cnt_clr) r_cnt <= '0;
    else if (cnt_en)  r_cnt <= r_cnt + W'(1);
  end
  assign cnt_value = ovr_en ? ovr_val : r_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input int lat, input int en);
    sb_t e;
    e.done = d;
    e.t0   = cyc;
    e.lat  = lat;
    e.en   = en;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int n, input int bound);
    int i = 0;
    while (sb.size() > n && i < bound) begin
      sample();
      i++;
    end
    if (sb.size() > n) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: %0d entries pending, expected at most %0d", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    req    = 2'b00;
    ovr_en = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    next_cyc();
    req  = v.req;
    dur0 = v.d0;
    dur1 = v.d1;
    push(v.gnt, v.lat, v.en);
    sample();
    chk("vec_idle_busy", 32'(busy), 32'(0));
    sample();
    chk("vec_gnt", 32'(gnt), 32'(v.gnt));
    chk("vec_cnt_clr", 32'(cnt_clr), 32'(v.en > 0));
    chk("vec_busy", 32'(busy), 32'(1));
    wait_sb(0, 1000);
    next_cyc();
    req = 2'b00;
    sample();
    chk("vec_busy_after", 32'(busy), 32'(0));
    chk("vec_gnt_after", 32'(gnt), 32'(0));
  endtask

  // Monitor: counts enabled cycles since the last clear and scores done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cnt_clr) en_since_clr = 0;
        else if (cnt_en) en_since_clr++;
        if (done != 2'b00) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'(0));
          end else begin
            mon_e = sb.pop_front();
            chk("done_bits", 32'(done), 32'(mon_e.done));
            chk("done_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            chk("done_gnt_held", 32'(gnt), 32'(mon_e.done));
            chk("done_cnt_en", 32'(cnt_en), 32'(0));
            if (mon_e.en >= 0) begin
              chk("run_cycles", 32'(en_since_clr), 32'(mon_e.en));
              chk("cnt_at_done", 32'(cnt_value), 32'(mon_e.en));
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    req     = 2'b00;
    dur0    = '0;
    dur1    = '0;
    ovr_en  = 1'b0;
    ovr_val = '0;

    vt[0] = '{2'b01, 16'd5,   16'd0, 2'b01, 7,   5};
    vt[1] = '{2'b10, 16'd9,   16'd0, 2'b10, 1,   -1};
    vt[2] = '{2'b10, 16'd0,   16'd1, 2'b10, 3,   1};
    vt[3] = '{2'b01, 16'd2,   16'd9, 2'b01, 4,   2};
    vt[4] = '{2'b11, 16'd7,   16'd3, 2'b10, 5,   3};
    vt[5] = '{2'b11, 16'd4,   16'd8, 2'b01, 6,   4};
    vt[6] = '{2'b01, 16'd300, 16'd5, 2'b01, 302, 300};

    next_cyc();
    sample();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt_clr", 32'(cnt_clr), 32'(0));
    chk("rst_cnt_en", 32'(cnt_en), 32'(0));
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Tie after reset, held request: 0, then 1, then 0 again.
    do_reset();
    next_cyc();
    req  = 2'b11;
    dur0 = 16'd3;
    dur1 = 16'd4;
    push(2'b01, 5, 3);
    push(2'b10, 12, 4);
    push(2'b01, 18, 3);
    wait_sb(2, 50);
    sample();
    chk("gap_gnt", 32'(gnt), 32'(0));
    chk("gap_busy", 32'(busy), 32'(0));
    wait_sb(0, 100);
    next_cyc();
    req = 2'b00;
    sample();
    chk("tie_busy_after", 32'(busy), 32'(0));

    // Abort on the 4th run cycle with requester 1 waiting.
    do_reset();
    next_cyc();
    req  = 2'b11;
    dur0 = 16'd10;
    dur1 = 16'd2;
    next_cyc();
    sample();
    chk("abort_gnt0", 32'(gnt), 32'(2'b01));
    for (int i = 0; i < 4; i++) next_cyc();
    req = 2'b10;
    push(2'b10, 5, 2);
    sample();
    chk("abort_run4_en", 32'(cnt_en), 32'(1));
    sample();
    chk("abort_gnt", 32'(gnt), 32'(0));
    chk("abort_cnt_en", 32'(cnt_en), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    wait_sb(0, 50);
    next_cyc();
    req = 2'b00;

    // Asynchronous reset between edges while running.
    do_reset();
    next_cyc();
    req  = 2'b01;
    dur0 = 16'd20;
    for (int i = 0; i < 4; i++) next_cyc();
    chk("pre_reset_gnt", 32'(gnt), 32'(2'b01));
    chk("pre_reset_en", 32'(cnt_en), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'(0));
    chk("async_cnt_en", 32'(cnt_en), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_done", 32'(done), 32'(0));
    next_cyc();
    req = 2'b00;
    next_cyc();
    rst = 1'b0;
    next_cyc();
    req  = 2'b11;
    dur0 = 16'd2;
    dur1 = 16'd3;
    push(2'b01, 4, 2);
    wait_sb(0, 50);
    next_cyc();
    req = 2'b00;

    // Duration change during RUN is ignored.
    next_cyc();
    req  = 2'b01;
    dur0 = 16'd6;
    push(2'b01, 8, 6);
    for (int i = 0; i < 3; i++) next_cyc();
    dur0 = 16'd2;
    wait_sb(0, 50);
    next_cyc();
    req = 2'b00;

    // Corrupted counter value above the target forces completion.
    next_cyc();
    req  = 2'b01;
    dur0 = 16'd10;
    push(2'b01, 5, 3);
    for (int i = 0; i < 4; i++) next_cyc();
    ovr_val = 16'hFFF0;
    ovr_en  = 1'b1;
    next_cyc();
    ovr_en = 1'b0;
    wait_sb(0, 20);
    next_cyc();
    req = 2'b00;
    sample();
    chk("final_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Time-shares one external WIDTH-bit up-counter between two requesters. Each requester uses it as a one-shot interval timer.
- Arbitrates with round-robin, clears the counter, and enables it for exactly the requested number of cycles. Then pulses done to the granted requester.
- Sits between requester logic and the counter instance in the top-level wrapper. It drives the counter's clear and enable and reads its value back.

Parameters:
- WIDTH, 16, width of counter value and duration inputs.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  per-requester request level; bit i = requester i
- dur0  input  WIDTH  requested duration in cycles for requester 0
- dur1  input  WIDTH  requested duration in cycles for requester 1
- gnt  output  2  one-hot grant; held while the requester owns the counter
- done  output  2  one-cycle pulse on the granted requester's bit at interval end
- busy  output  1  high whenever state != IDLE
- cnt_clr  output  1  synchronous clear to counter, one cycle
- cnt_en  output  1  count enable to counter; counter increments by 1 per cycle when high
- cnt_value  input  WIDTH  registered counter value

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- All outputs are registered.
- Reset (async, any time, including mid-operation):
  - state=IDLE; gnt=0, done=0, busy=0, cnt_clr=0, cnt_en=0; dur_q=0.
  - last-served pointer lsp=1, so requester 0 wins the first tie.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - Arbitration when req != 0:
    - Only one bit set: that requester wins.
    - Both set: requester != lsp wins.
  - Latch the winner's dur into dur_q and set gnt one-hot, both at the next edge.
  - If the latched dur == 0: go to DONE directly; no cnt_clr, no cnt_en.
  - Otherwise go to CLEAR.
- CLEAR: cnt_clr=1, cnt_en=0 for exactly one cycle, then RUN.
- RUN:
  - cnt_en=1 every cycle.
  - When cnt_value >= dur_q-1 (the final increment is in this cycle), go to DONE.
  - RUN lasts exactly dur_q cycles. The counter reads dur_q on entering DONE.
- DONE:
  - done[i]=1 for one cycle, gnt held, cnt_en=0.
  - Next state IDLE with gnt=0; lsp=i.
- Latency: req seen in IDLE at cycle t gives:
  - gnt and cnt_clr at t+1;
  - RUN over t+2..t+1+dur;
  - done at t+2+dur.
  - dur=0 case: done at t+1.
- Abort: granted requester drops req while in CLEAR or RUN:
  - Next edge: IDLE, gnt=0, cnt_en=0, no done pulse, lsp=i.
  - The counter is left at its current value.
- dur0/dur1 are sampled only at grant; later changes are ignored until the next grant.
- A req held high after done is a new request. It is arbitrated in the first IDLE cycle after DONE. A waiting peer wins over it via lsp.
- No back-to-back grants: at least one IDLE cycle separates grants.
- The non-granted requester's req is ignored (no queuing state) until IDLE.
- dur_q = all-ones (max): RUN lasts 2^WIDTH-1 cycles. The counter never wraps during a granted interval.
- If cnt_value is externally corrupted above dur_q-1, the >= compare forces exit to DONE on the next edge. No hang.

Test Plan:
- Single request, dur0=5: req=01 at t → gnt=01 and cnt_clr=1 at t+1; cnt_en high t+2..t+6; done=01 at t+7; cnt_value=5; busy low at t+8.
- Simultaneous, after reset: req=11, dur0=3, dur1=4 → requester 0 granted first, done[0] after 3 run cycles. Requester 1 granted on the next IDLE, done[1] after 4 run cycles. The next tie goes to requester 0.
- Zero duration: req=10, dur1=0 → gnt=10 and done=10 at t+1; cnt_clr and cnt_en never assert.
- Abort: dur0=10, drop req[0] on the 4th RUN cycle → next edge gnt=0, cnt_en=0, no done pulse. A pending req[1] is granted on the following IDLE evaluation.
- Async reset mid-RUN: assert rst between edges → gnt, cnt_en, busy and done go 0 immediately. After release, a tie with req=11 grants requester 0.
- Duration sampling: change dur0 from 6 to 2 during RUN → the interval still lasts 6 cycles; done[0] at t+8.
